// File: rtl/mem_stage_if.sv
// Handshake and payload bundle between the execute, memory and write-back stages.
// MS_LOAD_EXT_EN widens the execute-to-memory payload with a 3-bit load type.
`default_nettype none

interface mem_stage_if #(
`ifdef MS_LOAD_EXT_EN
  parameter int ES_TO_MS_BUS_WD = 74
`else
  parameter int ES_TO_MS_BUS_WD = 71
`endif
);
  logic                       ws_allowin;
  logic                       ms_allowin;
  logic                       es_to_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
  logic                       ms_to_ws_valid;
  logic [69:0]                ms_to_ws_bus;
  logic [31:0]                data_sram_rdata;
  logic [38:0]                ms_fwd_blk_bus;

  modport master (
    output ws_allowin, es_to_ms_valid, es_to_ms_bus, data_sram_rdata,
    input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_blk_bus
  );

  modport slave (
    input  ws_allowin, es_to_ms_valid, es_to_ms_bus, data_sram_rdata,
    output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_fwd_blk_bus
  );
endinterface

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// mem_stage : pipeline memory stage, holds first-cycle SRAM data across stalls
//             and forwards its result; MS_LOAD_EXT_EN adds lb/lbu/lh/lhu.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module mem_stage (
  input  logic       clk,
  input  logic       reset,
  mem_stage_if.slave ms
);

`ifdef MS_LOAD_EXT_EN
  localparam int ES_TO_MS_BUS_WD = 74;
`else
  localparam int ES_TO_MS_BUS_WD = 71;
`endif

  logic                       ms_valid;
  logic                       ms_first;
  logic                       hold_valid;
  logic [ES_TO_MS_BUS_WD-1:0] ms_bus;
  logic [31:0]                rdata_hold;

  logic        res_from_mem;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] exe_result;
  logic [31:0] pc;
  logic [31:0] load_word;
  logic [31:0] load_result;
  logic [31:0] final_result;
  logic        ms_allowin;
  logic        accept;
  logic        handoff;
  logic        capture;

  assign {res_from_mem, gr_we, dest, exe_result, pc} = ms_bus[70:0];

  // The stage is always ready to go, so handoff depends only on downstream.
  assign ms_allowin = !ms_valid || ms.ws_allowin;
  assign accept     = ms.es_to_ms_valid && ms_allowin;
  assign handoff    = ms_valid && ms.ws_allowin;
  assign capture    = ms_valid && res_from_mem && ms_first && !ms.ws_allowin;

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid   <= 1'b0;
      ms_first   <= 1'b0;
      hold_valid <= 1'b0;
    end else begin
      if (ms_allowin) begin
        ms_valid <= ms.es_to_ms_valid;
      end
      if (accept) begin
        ms_first <= 1'b1;
      end else if (ms_valid) begin
        ms_first <= 1'b0;
      end
      if (accept || handoff) begin
        hold_valid <= 1'b0;
      end else if (capture) begin
        hold_valid <= 1'b1;
      end
    end
  end

  // Payload and held data need no reset; ms_valid/hold_valid qualify them.
  always_ff @(posedge clk) begin
    if (accept) begin
      ms_bus <= ms.es_to_ms_bus;
    end
    if (capture) begin
      rdata_hold <= ms.data_sram_rdata;
    end
  end

  assign load_word = hold_valid ? rdata_hold : ms.data_sram_rdata;

`ifdef MS_LOAD_EXT_EN
  logic [2:0]  load_type;
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  assign load_type = ms_bus[73:71];

  always_comb begin
    load_byte = load_word[7:0];
    case (exe_result[1:0])
      2'd0: load_byte = load_word[7:0];
      2'd1: load_byte = load_word[15:8];
      2'd2: load_byte = load_word[23:16];
      2'd3: load_byte = load_word[31:24];
    endcase
    load_half = exe_result[1] ? load_word[31:16] : load_word[15:0];
    case (load_type)
      3'b001:  load_result = {{24{load_byte[7]}}, load_byte};
      3'b010:  load_result = {24'h0, load_byte};
      3'b011:  load_result = {{16{load_half[15]}}, load_half};
      3'b100:  load_result = {16'h0, load_half};
      default: load_result = load_word;
    endcase
  end
`else
  assign load_result = load_word;
`endif

  assign final_result = res_from_mem ? load_result : exe_result;

  assign ms.ms_allowin     = ms_allowin;
  assign ms.ms_to_ws_valid = ms_valid;
  assign ms.ms_to_ws_bus   = {gr_we, dest, final_result, pc};
  // Load data resolves here, so this stage never requests a block.
  assign ms.ms_fwd_blk_bus = {ms_valid && gr_we, dest, final_result, 1'b0};

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against a slot-level reference
// model: a load's result is whatever SRAM returned in its first cycle in the stage.
`default_nettype none

module tb_mem_stage;

`ifdef MS_LOAD_EXT_EN
  localparam int ES_W = 74;
  localparam bit EXT  = 1'b1;
`else
  localparam int ES_W = 71;
  localparam bit EXT  = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  mem_stage_if ifc ();

  mem_stage dut (
    .clk   (clk),
    .reset (reset),
    .ms    (ifc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: one slot, its payload and the first-cycle SRAM word.
  bit              m_valid = 1'b0;
  bit              m_first = 1'b0;
  logic [ES_W-1:0] m_bus   = '0;
  logic [31:0]     m_word  = '0;

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [ES_W-1:0] mk_bus(input logic [2:0] lt, input logic rfm,
                                             input logic we, input logic [4:0] d,
                                             input logic [31:0] exe, input logic [31:0] pc);
    return ES_W'({lt, rfm, we, d, exe, pc});
  endfunction

  function automatic logic [31:0] ld_model(input logic [31:0] w, input logic [2:0] lt,
                                           input logic [31:0] addr);
    int unsigned b;
    int unsigned h;
    if (!EXT) return w;
    b = (w >> (8 * addr[1:0])) & 32'hff;
    h = (w >> (16 * addr[1])) & 32'hffff;
    case (lt)
      3'd1:    return (b > 127) ? b - 256 : b;
      3'd2:    return b;
      3'd3:    return (h > 32767) ? h - 65536 : h;
      3'd4:    return h;
      default: return w;
    endcase
  endfunction

  // Drive one cycle of inputs, check outputs against the model, then advance the model.
  task automatic step(input bit ev, input logic [ES_W-1:0] b, input bit ws, input logic [31:0] rd);
    logic [31:0] fin;
    @(negedge clk);
    ifc.es_to_ms_valid  = ev;
    ifc.es_to_ms_bus    = b;
    ifc.ws_allowin      = ws;
    ifc.data_sram_rdata = rd;
    #1;
    if (m_valid && m_first) m_word = rd;
    fin = m_bus[70] ? ld_model(m_word, m_bus[ES_W-1 -: 3], m_bus[63:32]) : m_bus[63:32];
    chk("allowin", 70'(ifc.ms_allowin), 70'(!m_valid || ws));
    chk("to_ws_valid", 70'(ifc.ms_to_ws_valid), 70'(m_valid));
    chk("fwd_valid", 70'(ifc.ms_fwd_blk_bus[38]), 70'(m_valid && m_bus[69]));
    chk("blk_valid", 70'(ifc.ms_fwd_blk_bus[0]), 70'(0));
    if (m_valid) begin
      chk("ws_bus", ifc.ms_to_ws_bus, {m_bus[69:64], fin, m_bus[31:0]});
      chk("fwd_bus", 70'(ifc.ms_fwd_blk_bus[37:1]), 70'({m_bus[68:64], fin}));
    end
    if (!m_valid || ws) begin
      m_valid = ev;
      if (ev) begin
        m_bus   = b;
        m_first = 1'b1;
      end
    end else begin
      m_first = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset              = 1'b1;
    ifc.es_to_ms_valid = 1'b0;
    ifc.ws_allowin     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    m_valid = 1'b0;
    m_first = 1'b0;
    chk("rst_allowin", 70'(ifc.ms_allowin), 70'(1));
    chk("rst_valid", 70'(ifc.ms_to_ws_valid), 70'(0));
    chk("rst_fwd_valid", 70'(ifc.ms_fwd_blk_bus[38]), 70'(0));
  endtask

  initial begin
    logic [ES_W-1:0] idle;
    logic [2:0]      lt;
    idle                = '0;
    reset               = 1'b1;
    ifc.es_to_ms_valid  = 1'b0;
    ifc.es_to_ms_bus    = '0;
    ifc.ws_allowin      = 1'b0;
    ifc.data_sram_rdata = '0;
    do_reset();

    // Non-load forwarded with zero latency.
    step(1, mk_bus(0, 0, 1, 5, 32'h1234_5678, 32'h100), 1, 0);
    step(0, idle, 1, 32'h5555_5555);
    chk("nl_result", 70'(ifc.ms_to_ws_bus[63:32]), 70'(32'h1234_5678));
    chk("nl_fwd", 70'(ifc.ms_fwd_blk_bus[38:33]), 70'({1'b1, 5'd5}));

    // Unstalled lw.
    step(1, mk_bus(0, 1, 1, 7, 32'h2000, 32'h104), 1, 0);
    step(0, idle, 1, 32'hDEAD_BEEF);
    chk("lw_result", 70'(ifc.ms_to_ws_bus[63:32]), 70'(32'hDEAD_BEEF));
    chk("lw_blk", 70'(ifc.ms_fwd_blk_bus[0]), 70'(0));

    // Stalled lw: SRAM data changes after the first cycle.
    step(1, mk_bus(0, 1, 1, 8, 32'h2004, 32'h108), 1, 0);
    step(0, idle, 0, 32'hCAFE_0001);
    chk("stall_c1", 70'(ifc.ms_to_ws_bus[63:32]), 70'(32'hCAFE_0001));
    for (int i = 0; i < 2; i++) begin
      step(0, idle, 0, 32'h0);
      chk("stall_hold", 70'(ifc.ms_to_ws_bus[63:32]), 70'(32'hCAFE_0001));
      chk("stall_allowin", 70'(ifc.ms_allowin), 70'(0));
    end
    step(0, idle, 1, 32'h0);
    chk("stall_handoff", 70'(ifc.ms_to_ws_bus[63:32]), 70'(32'hCAFE_0001));
    chk("stall_ho_valid", 70'(ifc.ms_to_ws_valid), 70'(1));
    step(0, idle, 1, 32'h0);
    chk("stall_drained", 70'(ifc.ms_to_ws_valid), 70'(0));

    // Back-to-back load then add.
    step(1, mk_bus(0, 1, 1, 9, 32'h3000, 32'h10C), 1, 0);
    step(1, mk_bus(0, 0, 1, 10, 32'h0000_0042, 32'h110), 1, 32'h1111_2222);
    chk("b2b_ld", 70'(ifc.ms_to_ws_bus[63:32]), 70'(32'h1111_2222));
    chk("b2b_allow1", 70'(ifc.ms_allowin), 70'(1));
    step(0, idle, 1, 32'h9999_9999);
    chk("b2b_add", 70'(ifc.ms_to_ws_bus[63:32]), 70'(32'h42));
    chk("b2b_valid2", 70'(ifc.ms_to_ws_valid), 70'(1));

    // Reset in the middle of a stalled load.
    step(1, mk_bus(0, 1, 1, 11, 32'h4000, 32'h114), 1, 0);
    step(0, idle, 0, 32'h7777_7777);
    step(0, idle, 0, 32'h0);
    do_reset();

`ifdef MS_LOAD_EXT_EN
    step(1, mk_bus(3'd1, 1, 1, 12, 32'h5003, 32'h118), 1, 0);
    step(0, idle, 1, 32'h80FF_7F01);
    chk("lb_a3", 70'(ifc.ms_to_ws_bus[63:32]), 70'(32'hFFFF_FF80));
    step(1, mk_bus(3'd2, 1, 1, 12, 32'h5002, 32'h11C), 1, 0);
    step(0, idle, 1, 32'h80FF_7F01);
    chk("lbu_a2", 70'(ifc.ms_to_ws_bus[63:32]), 70'(32'h0000_00FF));
    step(1, mk_bus(3'd3, 1, 1, 12, 32'h5000, 32'h120), 1, 0);
    step(0, idle, 1, 32'h80FF_7F01);
    chk("lh_a0", 70'(ifc.ms_to_ws_bus[63:32]), 70'(32'h0000_7F01));
`endif

    for (int i = 0; i < 3000; i++) begin
      lt = EXT ? 3'($urandom_range(0, 4)) : 3'd0;
      step($urandom_range(0, 3) != 0,
           mk_bus(lt, 1'($urandom), 1'($urandom), 5'($urandom), $urandom, $urandom),
           $urandom_range(0, 2) != 0, $urandom);
      if (i % 700 == 350) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port ws_allowin  input  1  write-back stage can accept this cycle.
REQ-004 SHALL have port ms_allowin  output  1  this stage can accept from execute stage.
REQ-005 SHALL have port es_to_ms_valid  input  1  execute-stage payload valid.
REQ-006 SHALL have port es_to_ms_bus  input  ES_TO_MS_BUS_WD  fields: [70] res_from_mem, [69] gr_we, [68:64] dest, [63:32] exe_result (load address for loads), [31:0] pc.
REQ-007 SHALL have port ms_to_ws_valid  output  1  payload to write-back valid.
REQ-008 SHALL have port ms_to_ws_bus  output  70  fields: [69] gr_we, [68:64] dest, [63:32] final_result, [31:0] pc.
REQ-009 SHALL have port data_sram_rdata  input  32  synchronous-SRAM read data for the address the execute stage issued in the previous cycle.
REQ-010 SHALL have port ms_fwd_blk_bus  output  39  fields: [38] fwd_valid, [37:33] dest, [32:1] data, [0] blk_valid.

Function
REQ-011 SHALL hold ms_valid and a registered copy of es_to_ms_bus; on ms_allowin, ms_valid <= es_to_ms_valid, and the bus SHALL be captured only when es_to_ms_valid && ms_allowin.
REQ-012 SHALL drive ms_ready_go = 1, ms_allowin = !ms_valid || ws_allowin, ms_to_ws_valid = ms_valid.
REQ-013 SHALL set first-cycle flag ms_first = 1 on every accept and clear it after the first cycle with ms_valid = 1.
REQ-014 SHALL, when ms_valid && res_from_mem && ms_first && !ws_allowin, latch data_sram_rdata into rdata_hold and set hold_valid = 1.
REQ-015 SHALL clear hold_valid whenever the stage hands off (ms_valid && ws_allowin) or accepts a new instruction.
REQ-016 SHALL select load word = hold_valid ? rdata_hold : data_sram_rdata; SRAM data after the first cycle SHALL never be used directly.
REQ-017 SHALL set final_result = load result when res_from_mem, otherwise exe_result.
REQ-018 SHALL drive fwd_valid = ms_valid && gr_we, dest = registered dest, data = final_result.
REQ-019 SHALL drive blk_valid = 0, since load data resolves in this stage.
REQ-020 SHALL add zero latency to non-load and load results: result is presented in the same cycle as ms_valid.
REQ-021 SHALL, on a simultaneous handoff and accept, present the new instruction next cycle with ms_first = 1 and hold_valid = 0.

Reset
REQ-022 SHALL, while reset is asserted, force ms_valid = 0, ms_first = 0 and hold_valid = 0, so that ms_to_ws_valid = 0, fwd_valid = 0 and ms_allowin = 1 in the cycle after reset.
REQ-023 SHALL treat the payload and rdata_hold registers as don't-care after reset.
REQ-024 SHALL, on reset asserted mid-stall, discard the held instruction and its held data.

Configuration
REQ-025 SHALL use macro MS_LOAD_EXT_EN to select partial-load support.
REQ-026 SHALL, when MS_LOAD_EXT_EN is defined, widen ES_TO_MS_BUS_WD to 74, with [73:71] load_type: 000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu.
REQ-027 SHALL, when MS_LOAD_EXT_EN is defined, select byte/half from the load word by exe_result[1:0], half by exe_result[1], then sign-extend or zero-extend to 32 bits.
REQ-028 SHALL, when MS_LOAD_EXT_EN is undefined, use ES_TO_MS_BUS_WD = 71 and pass the whole load word as the load result.

Verification
REQ-029 SHALL verify non-load: exe_result 0x1234_5678, gr_we 1, dest 5, ws_allowin 1 -> same cycle ms_to_ws_bus final_result 0x1234_5678 and fwd_valid 1 with dest 5.
REQ-030 SHALL verify unstalled lw: rdata 0xDEAD_BEEF in the first cycle -> final_result 0xDEAD_BEEF and blk_valid 0.
REQ-031 SHALL verify stalled lw: rdata 0xCAFE_0001 in the first cycle, ws_allowin 0 for 3 cycles, rdata changed to 0x0 -> final_result stays 0xCAFE_0001 throughout and hands off when ws_allowin = 1.
REQ-032 SHALL verify back-to-back: a load followed by an add with ws_allowin 1 -> two consecutive valid handoffs with ms_allowin held at 1.
REQ-033 SHALL verify reset during a stalled load -> next cycle ms_to_ws_valid 0, fwd_valid 0, ms_allowin 1.
REQ-034 SHALL verify, with MS_LOAD_EXT_EN defined and word 0x80FF_7F01: lb at addr[1:0]=3 gives 0xFFFF_FF80, lbu at addr[1:0]=2 gives 0x0000_00FF, and lh at addr[1]=0 gives 0x0000_7F01.
